// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared state encoding, default parameters and width helper
package mux_sel_pkg;

    localparam logic ST_MANUAL = 1'b0;
    localparam logic ST_SCAN   = 1'b1;

    typedef enum logic {
        MANUAL = ST_MANUAL,
        SCAN   = ST_SCAN
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int SCAN_DIV_DEF        = 1000;
    localparam int SEL_W_DEF           = 2;

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// rtl/mux_sel_sequencer_if.sv - button/enable inputs and select/status outputs of the sequencer
interface mux_sel_sequencer_if import mux_sel_pkg::*; #(
    parameter int SEL_W = SEL_W_DEF
);
    logic             en;
    logic             btn_step;
    logic             btn_mode;
    logic [SEL_W-1:0] sel_out;
    logic             scan_active;
    logic             step_pulse;
    logic             sel_changed;

    modport master (
        output en, btn_step, btn_mode,
        input  sel_out, scan_active, step_pulse, sel_changed
    );

    modport slave (
        input  en, btn_step, btn_mode,
        output sel_out, scan_active, step_pulse, sel_changed
    );
endinterface

// File: rtl/mux_sel_sequencer_debounce_sync.sv
// rtl/mux_sel_sequencer_debounce_sync.sv - 2-flop sync, debounce counter, stable level and rising-edge pulse
module debounce_sync import mux_sel_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic pulse
);
    localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            // The synchronizer keeps tracking the pin even while disabled.
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (en) begin
                stable_d <= stable;
                pulse    <= stable & ~stable_d;
                if (sync2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - debounced step/mode buttons driving a MANUAL/SCAN select sequencer
module mux_sel_sequencer import mux_sel_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SCAN_DIV        = SCAN_DIV_DEF,
    parameter int SEL_W           = SEL_W_DEF
) (
    input logic                clk,
    input logic                rst,
    mux_sel_sequencer_if.slave bus
);
    localparam int            PW         = cnt_w(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    state_t           state;
    logic [PW-1:0]    presc;
    logic [SEL_W-1:0] sel_q;
    logic             sel_chg_q;
    logic             step_acc;
    logic             mode_acc;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .raw   (bus.btn_step),
        .pulse (step_acc)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .raw   (bus.btn_mode),
        .pulse (mode_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MANUAL;
            presc     <= '0;
            sel_q     <= '0;
            sel_chg_q <= 1'b0;
        end else begin
            sel_chg_q <= 1'b0;
            if (bus.en) begin
                // A mode toggle swallows a coincident step or terminal count.
                if (mode_acc) begin
                    state <= (state == MANUAL) ? SCAN : MANUAL;
                    presc <= '0;
                end else if (state == SCAN) begin
                    if (step_acc || presc == PRESC_LAST) begin
                        sel_q     <= sel_q + 1'b1;
                        sel_chg_q <= 1'b1;
                        presc     <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end else if (step_acc) begin
                    sel_q     <= sel_q + 1'b1;
                    sel_chg_q <= 1'b1;
                end
            end
        end
    end

    assign bus.sel_out     = sel_q;
    assign bus.scan_active = (state == SCAN);
    assign bus.step_pulse  = step_acc;
    assign bus.sel_changed = sel_chg_q;
endmodule
